// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control for the DLX pipeline.
// Issues instruction-memory reads over a req/ack handshake, keeps the PC
// (sequential step or branch redirect), honours decode stall back-pressure
// and squashes a wrong-path fetch that is still outstanding when a branch
// resolves. A memory that never answers parks the block in ERR until reset.
module fetch_sequencer #(
  parameter int unsigned          ADDR_W   = 32,
  parameter int unsigned          PC_STEP  = 1,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          MAX_WAIT = 15
) (
  input  logic              clock1,
  input  logic              reset1,
  input  logic              run,
  input  logic              stall_in,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       ir_out,
  output logic [ADDR_W-1:0] npc_out,
  output logic              ir_valid,
  output logic              busy,
  output logic              timeout_err
);

  // Wait counter is never narrower than 4 bits.
  localparam int unsigned WAIT_W = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   squash_tgt;
  logic                squash;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                fetch_ack;
  logic                timeout_hit;

  // An ack in the same cycle as the last allowed wait cycle completes the
  // fetch; only a cycle with no ack can time out.
  assign fetch_ack   = (state == S_FETCH) && imem_ack;
  assign timeout_hit = (state == S_FETCH) && !imem_ack && (wait_cnt == WAIT_LAST);

  // State register.
  always_ff @(posedge clock1 or posedge reset1) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset1) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned
    // (which would infer a latch).
    state_nxt = state;
    case (state)
      S_IDLE:  if (run) state_nxt = stall_in ? S_HOLD : S_FETCH;
      S_FETCH: begin
        if (fetch_ack)        state_nxt = (stall_in || !run) ? S_HOLD : S_FETCH;
        else if (timeout_hit) state_nxt = S_ERR;
      end
      S_HOLD: begin
        if (!run)          state_nxt = S_IDLE;
        else if (!stall_in) state_nxt = S_FETCH;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; request drops with reset.
  always_comb begin
    imem_req  = (state == S_FETCH);
    busy      = (state != S_IDLE);
    imem_addr = pc;
  end

  // PC, fetched-instruction registers, squash tracking and timeout counter.
  always_ff @(posedge clock1 or posedge reset1) begin
    if (reset1) begin
      pc          <= RESET_PC;
      ir_out      <= '0;
      npc_out     <= '0;
      ir_valid    <= 1'b0;
      timeout_err <= 1'b0;
      squash      <= 1'b0;
      squash_tgt  <= '0;
      wait_cnt    <= '0;
    end else begin
      ir_valid <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          wait_cnt <= '0;
          if (branch_en) pc <= branch_target;
        end
        S_FETCH: begin
          if (imem_ack) begin
            wait_cnt <= '0;
            squash   <= 1'b0;
            if (branch_en) begin
              pc <= branch_target;
            end else if (squash) begin
              pc <= squash_tgt;
            end else begin
              ir_out   <= imem_rdata;
              npc_out  <= pc;
              ir_valid <= 1'b1;
              pc       <= pc + ADDR_W'(PC_STEP);
            end
          end else begin
            // Outstanding request is wrong-path: remember where to go and
            // discard its data when the ack finally arrives.
            if (branch_en) begin
              squash     <= 1'b1;
              squash_tgt <= branch_target;
            end
            if (timeout_hit) timeout_err <= 1'b1;
            else             wait_cnt    <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios plus a randomized run checked
// against a transaction-level PC/delivery model.
module tb_fetch_sequencer;

  localparam int ADDR_W = 32;

  logic              clock1;
  logic              reset1;
  logic              run;
  logic              stall_in;
  logic              branch_en;
  logic [ADDR_W-1:0] branch_target;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;
  logic [31:0]       ir_out;
  logic [ADDR_W-1:0] npc_out;
  logic              ir_valid;
  logic              busy;
  logic              timeout_err;

  int checks;
  int errors;

  fetch_sequencer #(
    .ADDR_W(32), .PC_STEP(1), .RESET_PC('0), .MAX_WAIT(15)
  ) dut (
    .clock1(clock1), .reset1(reset1), .run(run), .stall_in(stall_in),
    .branch_en(branch_en), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir_out(ir_out), .npc_out(npc_out),
    .ir_valid(ir_valid), .busy(busy), .timeout_err(timeout_err)
  );

  initial clock1 = 1'b0;
  always #5 clock1 = ~clock1;

  // Instruction memory contents: word at address a is 0x1000 + a.
  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'h1000 + a;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  // All stimulus changes and all sampling happen on the falling edge.
  task automatic tick();
    @(negedge clock1);
  endtask

  task automatic do_reset();
    reset1 = 1'b1; run = 1'b0; stall_in = 1'b0; branch_en = 1'b0;
    branch_target = '0; imem_ack = 1'b0;
    repeat (2) tick();
    reset1 = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || ir_out !== 32'd0 || npc_out !== 32'd0 ||
        ir_valid !== 1'b0 || busy !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b addr=%h ir=%h npc=%h v=%b busy=%b to=%b, required all zero",
               imem_req, imem_addr, ir_out, npc_out, ir_valid, busy, timeout_err);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL seq_first_req: req=%b addr=%h v=%b, required req=1 addr=0 v=0", imem_req, imem_addr, ir_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (ir_valid !== 1'b1 || npc_out !== 32'(i) || ir_out !== 32'h1000 + 32'(i)) begin
        errors++;
        $display("FAIL seq_deliver[%0d]: v=%b npc=%h ir=%h, required v=1 npc=%h ir=%h",
                 i, ir_valid, npc_out, ir_out, i, 32'h1000 + 32'(i));
      end
    end
  endtask

  task automatic test_branch_wait();
    do_reset();
    branch_en = 1'b1; branch_target = 32'd5;
    tick();
    branch_en = 1'b0; run = 1'b1;
    tick();
    branch_en = 1'b1; branch_target = 32'h40;   // wait cycle 1 at addr 5
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd5) begin
      errors++;
      $display("FAIL bw_req5: req=%b addr=%h, required req=1 addr=5", imem_req, imem_addr);
    end
    tick();
    branch_en = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd5 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL bw_addr_stable: req=%b addr=%h v=%b, required req=1 addr=5 v=0", imem_req, imem_addr, ir_valid);
    end
    tick();
    imem_ack = 1'b1;                             // third cycle acks
    tick();
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      errors++;
      $display("FAIL bw_squash: v=%b req=%b addr=%h, required v=0 req=1 addr=40", ir_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || npc_out !== 32'h40 || ir_out !== 32'h1040) begin
      errors++;
      $display("FAIL bw_target_deliver: v=%b npc=%h ir=%h, required v=1 npc=40 ir=1040", ir_valid, npc_out, ir_out);
    end
  endtask

  task automatic test_stall();
    do_reset();
    run = 1'b1; imem_ack = 1'b1;
    repeat (3) tick();                           // FETCH at addr 2 now
    stall_in = 1'b1;
    tick();
    checks++;
    if (ir_valid !== 1'b1 || npc_out !== 32'd2 || ir_out !== 32'h1002 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL stall_deliver2: v=%b npc=%h ir=%h req=%b, required v=1 npc=2 ir=1002 req=0",
               ir_valid, npc_out, ir_out, imem_req);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: req=%b v=%b, required req=0 v=0", i, imem_req, ir_valid);
      end
    end
    stall_in = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd3) begin
      errors++;
      $display("FAIL stall_resume: req=%b addr=%h, required req=1 addr=3", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_on_ack();
    do_reset();
    branch_en = 1'b1; branch_target = 32'd7;
    tick();
    branch_en = 1'b0; run = 1'b1;
    tick();
    imem_ack = 1'b1; branch_en = 1'b1; branch_target = 32'h80;
    tick();
    branch_en = 1'b0;
    checks++;
    if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      errors++;
      $display("FAIL boa_redirect: v=%b req=%b addr=%h, required v=0 req=1 addr=80", ir_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (ir_valid !== 1'b1 || npc_out !== 32'h80) begin
      errors++;
      $display("FAIL boa_deliver: v=%b npc=%h, required v=1 npc=80", ir_valid, npc_out);
    end
  endtask

  task automatic test_timeout();
    int bad;
    do_reset();
    run = 1'b1;
    tick();
    bad = 0;
    for (int i = 1; i <= 15; i++) begin
      if (imem_req !== 1'b1 || timeout_err !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_waiting: %0d of 15 wait cycles had req!=1 or early timeout, required 0", bad);
    end
    checks++;
    if (timeout_err !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL to_err: to=%b req=%b busy=%b, required to=1 req=0 busy=1", timeout_err, imem_req, busy);
    end
    imem_ack = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ir_valid !== 1'b0 || imem_req !== 1'b0 || timeout_err !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL to_sticky: %0d cycles after late ack were not (v=0 req=0 to=1), required 0", bad);
    end
    do_reset();
    checks++;
    if (timeout_err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_clear: to=%b busy=%b, required to=0 busy=0", timeout_err, busy);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    run = 1'b1; imem_ack = 1'b1; branch_en = 1'b1; branch_target = 32'd8;
    tick();
    branch_en = 1'b0;
    tick();
    imem_ack = 1'b0;                             // fetch at addr 9 left open
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd9 || npc_out !== 32'd8 || ir_out !== 32'h1008) begin
      errors++;
      $display("FAIL ri_setup: req=%b addr=%h npc=%h ir=%h, required req=1 addr=9 npc=8 ir=1008",
               imem_req, imem_addr, npc_out, ir_out);
    end
    #2 reset1 = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'd0 || npc_out !== 32'd0 || ir_out !== 32'd0) begin
      errors++;
      $display("FAIL ri_async: req=%b addr=%h npc=%h ir=%h, required all 0", imem_req, imem_addr, npc_out, ir_out);
    end
    tick();
    reset1 = 1'b0; imem_ack = 1'b1;             // late ack is ignored in IDLE
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL ri_restart: req=%b addr=%h v=%b, required req=1 addr=0 v=0", imem_req, imem_addr, ir_valid);
    end
  endtask

  // Randomized run: model tracks only the architectural next PC, whether a
  // branch has made the outstanding fetch wrong-path, and which instruction
  // must appear one cycle after each accepted ack.
  task automatic test_random();
    logic [ADDR_W-1:0] exp_pc, exp_npc;
    logic exp_v, pend, in_txn;
    int delay, delivered, bad_v, bad_d, bad_a;
    do_reset();
    exp_pc = '0; exp_npc = '0; exp_v = 1'b0; pend = 1'b0; in_txn = 1'b0;
    delay = 0; delivered = 0; bad_v = 0; bad_d = 0; bad_a = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (ir_valid !== exp_v) begin
        bad_v++;
        if (bad_v < 4) $display("FAIL rnd_valid@%0d: v=%b, required %b", cyc, ir_valid, exp_v);
      end else if (exp_v && (npc_out !== exp_npc || ir_out !== mem_word(exp_npc))) begin
        bad_d++;
        if (bad_d < 4) $display("FAIL rnd_data@%0d: npc=%h ir=%h, required npc=%h ir=%h",
                                cyc, npc_out, ir_out, exp_npc, mem_word(exp_npc));
      end
      if (exp_v) delivered++;
      if (imem_req === 1'b1 && !pend && imem_addr !== exp_pc) begin
        bad_a++;
        if (bad_a < 4) $display("FAIL rnd_addr@%0d: addr=%h, required %h", cyc, imem_addr, exp_pc);
      end
      run           = ($urandom_range(7) != 0);
      stall_in      = ($urandom_range(3) == 0);
      branch_en     = ($urandom_range(11) == 0);
      branch_target = $urandom;
      if (imem_req === 1'b1) begin
        if (!in_txn) begin in_txn = 1'b1; delay = $urandom_range(3); end
        imem_ack = (delay == 0);
        if (imem_ack) in_txn = 1'b0;
        else          delay--;
      end else begin
        in_txn   = 1'b0;
        imem_ack = ($urandom_range(2) == 0);
      end
      exp_v = 1'b0;
      if (imem_req === 1'b1 && imem_ack) begin
        if (!pend && !branch_en) begin
          exp_v = 1'b1; exp_npc = exp_pc; exp_pc = exp_pc + 1;
        end
        pend = 1'b0;
      end
      if (branch_en) begin
        exp_pc = branch_target;
        if (imem_req === 1'b1 && !imem_ack) pend = 1'b1;
      end
      tick();
    end
    checks++;
    if (bad_v != 0) begin errors++; $display("FAIL rnd_valid_total: %0d mismatches, required 0", bad_v); end
    checks++;
    if (bad_d != 0) begin errors++; $display("FAIL rnd_data_total: %0d mismatches, required 0", bad_d); end
    checks++;
    if (bad_a != 0) begin errors++; $display("FAIL rnd_addr_total: %0d mismatches, required 0", bad_a); end
    checks++;
    if (delivered < 200 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL rnd_progress: delivered=%0d to=%b, required >=200 and to=0", delivered, timeout_err);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset1 = 1'b1; run = 1'b0; stall_in = 1'b0; branch_en = 1'b0;
    branch_target = '0; imem_ack = 1'b0;
    test_reset();
    test_sequential();
    test_branch_wait();
    test_stall();
    test_branch_on_ack();
    test_timeout();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
